set_assoc_dcache: RTL and testbench

- Parametrised, blocking, write-through / write-allocate data cache between the pipeline MEM stage and the multicycle memory.
- Generalises the fixed 2-way, 64-set, 8-word cache in set count, line length and associativity (1 or 2 ways).
- Absorbs the miss-fill FSM, write-through handshake, LRU replacement, whole-cache invalidate and hit/miss statistics counters.

---
 rtl/set_assoc_dcache.sv | 216 +++++++++++++++++++++
 tb/tb_set_assoc_dcache.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_dcache.sv
// Blocking write-through / write-allocate data cache with 1- or 2-way LRU replacement.
// Sits between the MEM stage and a multicycle memory; also keeps saturating hit/miss counters.
//
// state   | meaning
// S_IDLE  | lookup; load hits served combinationally
// S_FILL  | refilling the victim line one word at a time
// S_WRITE | write-through waiting for mem_wr_ack

module set_assoc_dcache #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int NUM_SETS       = 64,
  parameter int WORDS_PER_LINE = 8,
  parameter int WAYS           = 2,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              inv_all,
  output logic [DATA_W-1:0] rdata,
  output logic              stall,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_wr_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 1;

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE} state_e;

  state_e                        state_q, state_d;
  logic [OFF_W-1:0]              fill_idx_q, fill_idx_d;
  logic                          victim_q, victim_d;
  logic                          wr_done_q, wr_done_d;
  logic [CNT_W-1:0]              hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]              miss_cnt_q, miss_cnt_d;
  logic [WAYS-1:0][NUM_SETS-1:0] valid_q;
  logic [NUM_SETS-1:0]           lru_q;

  logic [TAG_W-1:0]  tag_q  [WAYS][NUM_SETS];
  logic [DATA_W-1:0] data_q [WAYS][NUM_SETS][WORDS_PER_LINE];

  logic [OFF_W-1:0]  req_off;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WAYS-1:0]   way_hit;
  logic              hit;
  logic              hit_way;
  logic              victim_sel;
  logic [DATA_W-1:0] hit_word;

  logic inv_now, start_fill, fill_we, fill_last, wr_we, lru_we, lru_val;

  assign req_off = req_addr[OFF_W:1];
  assign req_idx = req_addr[OFF_W+IDX_W:OFF_W+1];
  assign req_tag = req_addr[ADDR_W-1:OFF_W+IDX_W+1];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_comb begin
    way_hit  = '0;
    hit_word = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_hit[w] = valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag);
      if (way_hit[w]) hit_word = data_q[w][req_idx][req_off];
    end
    hit     = |way_hit;
    hit_way = (WAYS == 2) ? way_hit[WAYS-1] : 1'b0;
  end

  // Prefer an empty way (way0 first) before evicting the LRU one.
  always_comb begin
    victim_sel = 1'b0;
    if (WAYS == 2) begin
      if (!valid_q[0][req_idx])           victim_sel = 1'b0;
      else if (!valid_q[WAYS-1][req_idx]) victim_sel = 1'b1;
      else                                victim_sel = lru_q[req_idx];
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_idx_d = fill_idx_q;
    victim_d   = victim_q;
    wr_done_d  = 1'b0;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    rdata      = '0;
    stall      = 1'b0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    inv_now    = 1'b0;
    start_fill = 1'b0;
    fill_we    = 1'b0;
    fill_last  = 1'b0;
    wr_we      = 1'b0;
    lru_we     = 1'b0;
    lru_val    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (inv_all) begin
          inv_now = 1'b1;
          stall   = req_valid;
        end else if (req_valid) begin
          if (hit && !req_we) begin
            rdata     = hit_word;
            hit_cnt_d = sat_inc(hit_cnt_q);
            lru_we    = 1'b1;
            lru_val   = ~hit_way;
          end else if (hit && wr_done_q) begin
            // store already written through last cycle; just release the core
          end else if (hit) begin
            stall     = 1'b1;
            hit_cnt_d = sat_inc(hit_cnt_q);
            state_d   = S_WRITE;
          end else begin
            stall      = 1'b1;
            miss_cnt_d = sat_inc(miss_cnt_q);
            start_fill = 1'b1;
            victim_d   = victim_sel;
            fill_idx_d = '0;
            state_d    = S_FILL;
          end
        end
      end
      S_FILL: begin
        stall      = req_valid;
        mem_rd_req = 1'b1;
        mem_addr   = {req_tag, req_idx, fill_idx_q, 1'b0};
        if (mem_rd_valid) begin
          fill_we    = 1'b1;
          fill_idx_d = fill_idx_q + OFF_W'(1);
          if (fill_idx_q == OFF_W'(WORDS_PER_LINE - 1)) begin
            fill_last  = 1'b1;
            fill_idx_d = '0;
            state_d    = S_IDLE;
          end
        end
      end
      S_WRITE: begin
        stall      = req_valid;
        mem_wr_req = 1'b1;
        mem_addr   = req_addr & ~ADDR_W'(1);
        mem_wdata  = req_wdata;
        if (mem_wr_ack) begin
          wr_we     = hit;
          lru_we    = 1'b1;
          lru_val   = ~hit_way;
          wr_done_d = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The victim is invalidated as the fill starts so a reset mid-fill never exposes a torn line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fill_idx_q <= '0;
      victim_q   <= 1'b0;
      wr_done_q  <= 1'b0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      valid_q    <= '0;
      lru_q      <= '0;
    end else begin
      state_q    <= state_d;
      fill_idx_q <= fill_idx_d;
      victim_q   <= victim_d;
      wr_done_q  <= wr_done_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      if (inv_now) begin
        valid_q <= '0;
        lru_q   <= '0;
      end else begin
        if (lru_we) lru_q[req_idx] <= lru_val;
        for (int w = 0; w < WAYS; w++) begin
          if (start_fill && victim_d == w[0]) valid_q[w][req_idx] <= 1'b0;
          if (fill_last && victim_q == w[0])  valid_q[w][req_idx] <= 1'b1;
        end
        if (fill_last) lru_q[req_idx] <= ~victim_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int w = 0; w < WAYS; w++) begin
      if (fill_we && victim_q == w[0])   data_q[w][req_idx][fill_idx_q] <= mem_rdata;
      if (fill_last && victim_q == w[0]) tag_q[w][req_idx] <= req_tag;
      if (wr_we && way_hit[w])           data_q[w][req_idx][req_off] <= req_wdata;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_set_assoc_dcache.sv
// Directed bench for set_assoc_dcache: a 2-way instance and a 1-way instance with 2-bit counters.
// Memory returns the word address as fill data, one cycle after each read request appears.

module tb_set_assoc_dcache;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid, req_we, inv_all;
  logic [15:0] req_addr, req_wdata;
  logic        mem_rd_valid, mem_wr_ack;
  logic [15:0] mem_rdata;

  logic [15:0] a_rdata, a_mem_addr, a_mem_wdata, a_hit, a_miss;
  logic        a_stall, a_rd_req, a_wr_req;
  logic [15:0] b_rdata, b_mem_addr, b_mem_wdata;
  logic [1:0]  b_hit, b_miss;
  logic        b_stall, b_rd_req, b_wr_req;

  logic [15:0] rdata, mem_addr, mem_wdata;
  logic        stall, mem_rd_req, mem_wr_req;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  set_assoc_dcache u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & ~sel), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .inv_all(inv_all & ~sel), .rdata(a_rdata), .stall(a_stall),
    .mem_rd_req(a_rd_req), .mem_wr_req(a_wr_req), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rd_valid(mem_rd_valid & ~sel), .mem_rdata(mem_rdata), .mem_wr_ack(mem_wr_ack & ~sel),
    .hit_count(a_hit), .miss_count(a_miss)
  );

  set_assoc_dcache #(.WAYS(1), .CNT_W(2)) u_dm (
    .clk(clk), .rst(rst),
    .req_valid(req_valid & sel), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .inv_all(inv_all & sel), .rdata(b_rdata), .stall(b_stall),
    .mem_rd_req(b_rd_req), .mem_wr_req(b_wr_req), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rd_valid(mem_rd_valid & sel), .mem_rdata(mem_rdata), .mem_wr_ack(mem_wr_ack & sel),
    .hit_count(b_hit), .miss_count(b_miss)
  );

  assign rdata      = sel ? b_rdata     : a_rdata;
  assign stall      = sel ? b_stall     : a_stall;
  assign mem_rd_req = sel ? b_rd_req    : a_rd_req;
  assign mem_wr_req = sel ? b_wr_req    : a_wr_req;
  assign mem_addr   = sel ? b_mem_addr  : a_mem_addr;
  assign mem_wdata  = sel ? b_mem_wdata : a_mem_wdata;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // memory model
  logic        rd_en = 1'b1;
  logic        late_pulse = 1'b0;
  int          wr_delay = 1;
  int          rd_n = 0;
  logic [15:0] rd_log [16];
  int          wr_cyc = 0;
  logic [15:0] last_wr_addr, last_wr_data;
  logic        both_seen = 1'b0;

  initial begin
    logic seen;
    int   wr_n;
    seen = 1'b0; wr_n = 0;
    mem_rd_valid = 1'b0; mem_wr_ack = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      mem_rd_valid = 1'b0;
      mem_wr_ack   = 1'b0;
      if (late_pulse) begin
        mem_rd_valid = 1'b1;
        mem_rdata    = 16'hDEAD;
        late_pulse   = 1'b0;
      end else if (rd_en && mem_rd_req) begin
        if (seen) begin
          mem_rd_valid = 1'b1;
          mem_rdata    = mem_addr;
          if (rd_n < 16) rd_log[rd_n] = mem_addr;
          rd_n++;
          seen = 1'b0;
        end else seen = 1'b1;
      end else seen = 1'b0;
      if (mem_wr_req) begin
        wr_n++;
        if (wr_n >= wr_delay) begin
          mem_wr_ack = 1'b1;
          wr_n = 0;
        end
      end else wr_n = 0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (mem_wr_req) begin
      wr_cyc++;
      last_wr_addr = mem_addr;
      last_wr_data = mem_wdata;
    end
    if (mem_rd_req && mem_wr_req) both_seen = 1'b1;
  end

  // One core access held until stall drops; inv_all rides along in cycle inv_at (-1 = never).
  task automatic access(input logic we, input logic [15:0] a, input logic [15:0] d,
                        input int inv_at, output int stalls, output logic [15:0] rd);
    stalls = 0;
    rd = '0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    inv_all = (inv_at == 0);
    forever begin
      @(negedge clk);
      if (!stall) begin
        rd = rdata;
        break;
      end
      stalls++;
      if (stalls > 300) begin
        check_val("access_timeout", {31'b0, stall}, 32'h0);
        break;
      end
      @(posedge clk); #1;
      inv_all = (inv_at == stalls);
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; inv_all = 1'b0;
  endtask

  task automatic check_fill(input string tag, input logic [15:0] base);
    check_val({tag, "_nreads"}, rd_n, 8);
    for (int i = 0; i < 8 && i < rd_n; i++)
      check_val($sformatf("%s_rdaddr%0d", tag, i), rd_log[i], base + 16'(2 * i));
  endtask

  task automatic load(input string tag, input logic [15:0] a, input int exp_stalls,
                      input logic [15:0] exp_data);
    int          st;
    logic [15:0] rd;
    access(1'b0, a, 16'h0, -1, st, rd);
    check_val({tag, "_stalls"}, st, exp_stalls);
    check_val({tag, "_rdata"}, rd, exp_data);
  endtask

  initial begin
    int          st;
    logic [15:0] rd;
    rst = 1'b1; sel = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; inv_all = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("rst_stall", stall, 0);
    check_val("rst_rd_req", mem_rd_req, 0);
    check_val("rst_wr_req", mem_wr_req, 0);
    check_val("rst_mem_addr", mem_addr, 0);
    check_val("rst_rdata", rdata, 0);
    check_val("rst_hits", a_hit, 0);
    check_val("rst_misses", a_miss, 0);

    // first miss: 8 word refill then replay hit
    rd_n = 0;
    load("miss1234", 16'h1234, 17, 16'h1234);
    check_fill("miss1234", 16'h1230);
    check_val("miss1234_hits", a_hit, 1);
    check_val("miss1234_misses", a_miss, 1);

    // store hit, write-through acked on its third request cycle
    wr_delay = 3; wr_cyc = 0;
    access(1'b1, 16'h1236, 16'hBEEF, -1, st, rd);
    check_val("st_stalls", st, 4);
    check_val("st_wr_cycles", wr_cyc, 3);
    check_val("st_wr_addr", last_wr_addr, 16'h1236);
    check_val("st_wr_data", last_wr_data, 16'hBEEF);
    load("ld1236", 16'h1236, 0, 16'hBEEF);
    load("ld1238", 16'h1238, 0, 16'h1238);

    // LRU in set 0
    load("lru_a", 16'h0400, 17, 16'h0400);
    load("lru_b", 16'h0800, 17, 16'h0800);
    load("lru_touch_a", 16'h0400, 0, 16'h0400);
    load("lru_c", 16'h0C00, 17, 16'h0C00);
    load("lru_a_stays", 16'h0400, 0, 16'h0400);
    load("lru_b_gone", 16'h0802, 17, 16'h0802);

    // inv_all together with a request to a resident line: inv wins, then full refill
    rd_n = 0;
    access(1'b0, 16'h1234, 16'h0, 0, st, rd);
    check_val("inv_req_stalls", st, 18);
    check_val("inv_req_rdata", rd, 16'h1234);
    check_fill("inv_req", 16'h1230);

    // inv_all during FILL is ignored
    rd_n = 0;
    access(1'b0, 16'h2040, 16'h0, 5, st, rd);
    check_val("inv_fill_stalls", st, 17);
    check_val("inv_fill_rdata", rd, 16'h2040);
    check_fill("inv_fill", 16'h2040);
    load("after_inv_fill", 16'h1234, 0, 16'h1234);

    // plain pulse in IDLE
    @(posedge clk); #1 inv_all = 1'b1;
    @(posedge clk); #1 inv_all = 1'b0;
    load("after_pulse", 16'h2042, 17, 16'h2042);

    // store miss: fill, replay hit, write-through
    wr_delay = 1; wr_cyc = 0; rd_n = 0;
    access(1'b1, 16'h3108, 16'h5555, -1, st, rd);
    check_val("stmiss_stalls", st, 19);
    check_val("stmiss_wr_cycles", wr_cyc, 1);
    check_val("stmiss_wr_addr", last_wr_addr, 16'h3108);
    check_fill("stmiss", 16'h3100);
    load("stmiss_ld", 16'h3108, 0, 16'h5555);
    load("stmiss_ld2", 16'h310A, 0, 16'h310A);

    // reset after the fourth fill word
    rd_n = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h4450;
    for (int i = 0; i < 200 && rd_n < 4; i++) begin
      @(posedge clk); #1;
    end
    check_val("rstfill_words", rd_n, 4);
    rd_en = 1'b0; rst = 1'b1; req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_val("rstfill_rd_req", mem_rd_req, 0);
    check_val("rstfill_mem_addr", mem_addr, 0);
    check_val("rstfill_stall", stall, 0);
    check_val("rstfill_rdata", rdata, 0);
    @(posedge clk); #1;
    rst = 1'b0; late_pulse = 1'b1;
    @(negedge clk);
    check_val("late_valid_rd_req", mem_rd_req, 0);
    @(posedge clk); #1;
    check_val("late_valid_hits", a_hit, 0);
    check_val("late_valid_misses", a_miss, 0);
    rd_en = 1'b1; rd_n = 0;
    load("refetch", 16'h4450, 17, 16'h4450);
    check_fill("refetch", 16'h4450);
    check_val("refetch_hits", a_hit, 1);
    check_val("refetch_misses", a_miss, 1);
    check_val("rd_wr_overlap", both_seen, 0);

    // direct-mapped instance, 2-bit counters
    @(posedge clk); #1 sel = 1'b1;
    load("dm_a", 16'h0400, 17, 16'h0400);
    load("dm_a_hit", 16'h0400, 0, 16'h0400);
    load("dm_b", 16'h0800, 17, 16'h0800);
    check_val("dm_b_hits", b_hit, 3);
    check_val("dm_b_misses", b_miss, 2);
    load("dm_a_evicted", 16'h0400, 17, 16'h0400);
    check_val("dm_hit_sat", b_hit, 3);
    check_val("dm_misses3", b_miss, 3);
    load("dm_a_hit2", 16'h0400, 0, 16'h0400);
    check_val("dm_hit_sat2", b_hit, 3);
    load("dm_b_again", 16'h0800, 17, 16'h0800);
    check_val("dm_miss_sat", b_miss, 3);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
